// File: rtl/tcam_rule_install_ctrl.sv
// Installs one TCAM rule (action, mask, key) or the default action. Lookups are
// stalled and the in-flight ones are drained first, so no lookup sees a half-written rule.
module tcam_rule_install_ctrl #(
   parameter int KEY_W         = 128,
   parameter int ACTION_W      = 64,
   parameter int TCAM_ENTRIES  = 16,
   parameter int CNT_W         = 4,
   parameter int DRAIN_TIMEOUT = 255,
   localparam int IDX_W        = $clog2(TCAM_ENTRIES)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_is_default,
   input  logic [IDX_W-1:0]    req_addr,
   input  logic [KEY_W-1:0]    req_key,
   input  logic [KEY_W-1:0]    req_mask,
   input  logic [ACTION_W-1:0] req_action,
   input  logic                lookup_issue,
   input  logic                lookup_retire,
   output logic                hold_lookup,
   output logic                cfg_tcam_wr_en,
   output logic                cfg_tcam_wr_is_mask,
   output logic [IDX_W-1:0]    cfg_tcam_wr_addr,
   output logic [KEY_W-1:0]    cfg_tcam_wr_data,
   output logic                cfg_action_wr_en,
   output logic [IDX_W-1:0]    cfg_action_wr_addr,
   output logic [ACTION_W-1:0] cfg_action_wr_data,
   output logic                cfg_action_wr_default,
   output logic [ACTION_W-1:0] cfg_action_default_data,
   output logic                done,
   output logic                done_err,
   output logic                cnt_err
);

   localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_STALL   = 3'd1,
      S_WR_ACT  = 3'd2,
      S_WR_MASK = 3'd3,
      S_WR_KEY  = 3'd4,
      S_RELEASE = 3'd5
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                cnt_err_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                is_def_q;
   logic [IDX_W-1:0]    addr_q;
   logic [KEY_W-1:0]    key_q, mask_q;
   logic [ACTION_W-1:0] act_q;
   logic                drained_s, stall_exit_s, abort_s;

   // In-flight lookup counter; saturating at both ends with a sticky error
   always_comb begin
      cnt_d     = cnt_q;
      cnt_err_d = cnt_err;
      if (lookup_issue && !lookup_retire) begin
         if (cnt_q == '1) cnt_err_d = 1'b1;
         else             cnt_d     = cnt_q + CNT_W'(1);
      end else if (lookup_retire && !lookup_issue) begin
         if (cnt_q == '0) cnt_err_d = 1'b1;
         else             cnt_d     = cnt_q - CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Drain uses this cycle's retire so the write starts right after the last lookup leaves
   assign drained_s    = (cnt_d == '0) && !lookup_issue;
   assign stall_exit_s = (state_q == S_STALL) && drained_s;
   assign abort_s      = (state_q == S_STALL) && !drained_s && (tmo_q == TMO_LAST);

   // Next-state and drain-timeout logic
   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d = S_STALL;
               tmo_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_STALL: begin
            if (drained_s)                 state_d = is_def_q ? S_RELEASE : S_WR_ACT;
            else if (tmo_q == TMO_LAST)    state_d = S_RELEASE;
            else                           tmo_d   = tmo_q + TMO_W'(1);
         end
         S_WR_ACT:  state_d = S_WR_MASK;
         S_WR_MASK: state_d = S_WR_KEY;
         S_WR_KEY:  state_d = S_RELEASE;
         S_RELEASE: state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // State, request latch and registered outputs decoded from the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q                 <= S_IDLE;
         cnt_q                   <= '0;
         tmo_q                   <= '0;
         is_def_q                <= 1'b0;
         addr_q                  <= '0;
         key_q                   <= '0;
         mask_q                  <= '0;
         act_q                   <= '0;
         req_ready               <= 1'b1;
         hold_lookup             <= 1'b0;
         cfg_tcam_wr_en          <= 1'b0;
         cfg_tcam_wr_is_mask     <= 1'b0;
         cfg_tcam_wr_addr        <= '0;
         cfg_tcam_wr_data        <= '0;
         cfg_action_wr_en        <= 1'b0;
         cfg_action_wr_addr      <= '0;
         cfg_action_wr_data      <= '0;
         cfg_action_wr_default   <= 1'b0;
         cfg_action_default_data <= '0;
         done                    <= 1'b0;
         done_err                <= 1'b0;
         cnt_err                 <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cnt_err <= cnt_err_d;
         tmo_q   <= tmo_d;
         if ((state_q == S_IDLE) && req_valid) begin
            is_def_q <= req_is_default;
            addr_q   <= req_addr;
            key_q    <= req_key;
            mask_q   <= req_mask;
            act_q    <= req_action;
         end
         req_ready   <= (state_d == S_IDLE);
         hold_lookup <= (state_d inside {S_STALL, S_WR_ACT, S_WR_MASK, S_WR_KEY});
         done        <= (state_d == S_RELEASE);
         done_err    <= abort_s;
         cfg_action_wr_en      <= (state_d == S_WR_ACT);
         cfg_tcam_wr_en        <= (state_d == S_WR_MASK) || (state_d == S_WR_KEY);
         cfg_action_wr_default <= stall_exit_s && is_def_q;
         if (state_d == S_WR_ACT) begin
            cfg_action_wr_addr <= addr_q;
            cfg_action_wr_data <= act_q;
         end
         if (state_d == S_WR_MASK) begin
            cfg_tcam_wr_is_mask <= 1'b1;
            cfg_tcam_wr_addr    <= addr_q;
            cfg_tcam_wr_data    <= mask_q;
         end else if (state_d == S_WR_KEY) begin
            cfg_tcam_wr_is_mask <= 1'b0;
            cfg_tcam_wr_addr    <= addr_q;
            cfg_tcam_wr_data    <= key_q;
         end
         if (stall_exit_s && is_def_q) cfg_action_default_data <= act_q;
      end
   end

endmodule

// File: tb/tb_tcam_rule_install_ctrl.sv
// Bench for tcam_rule_install_ctrl: request table plus scoreboard of expected
// write/done strobes, and hand sequences for counter and reset corner cases.
module tb_tcam_rule_install_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid, req_ready, req_is_default;
   logic [3:0]   req_addr;
   logic [127:0] req_key, req_mask;
   logic [63:0]  req_action;
   logic         lookup_issue, lookup_retire, hold_lookup;
   logic         cfg_tcam_wr_en, cfg_tcam_wr_is_mask;
   logic [3:0]   cfg_tcam_wr_addr;
   logic [127:0] cfg_tcam_wr_data;
   logic         cfg_action_wr_en;
   logic [3:0]   cfg_action_wr_addr;
   logic [63:0]  cfg_action_wr_data;
   logic         cfg_action_wr_default;
   logic [63:0]  cfg_action_default_data;
   logic         done, done_err, cnt_err;

   tcam_rule_install_ctrl #(.DRAIN_TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_is_default(req_is_default),
      .req_addr(req_addr), .req_key(req_key), .req_mask(req_mask), .req_action(req_action),
      .lookup_issue(lookup_issue), .lookup_retire(lookup_retire), .hold_lookup(hold_lookup),
      .cfg_tcam_wr_en(cfg_tcam_wr_en), .cfg_tcam_wr_is_mask(cfg_tcam_wr_is_mask),
      .cfg_tcam_wr_addr(cfg_tcam_wr_addr), .cfg_tcam_wr_data(cfg_tcam_wr_data),
      .cfg_action_wr_en(cfg_action_wr_en), .cfg_action_wr_addr(cfg_action_wr_addr),
      .cfg_action_wr_data(cfg_action_wr_data), .cfg_action_wr_default(cfg_action_wr_default),
      .cfg_action_default_data(cfg_action_default_data),
      .done(done), .done_err(done_err), .cnt_err(cnt_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         is_def;
      logic [3:0]   addr;
      logic [127:0] key;
      logic [127:0] mask;
      logic [63:0]  act;
      int           n_issue;
      int           ret1;
      int           ret2;
      logic         exp_err;
      int           done_cyc;
   } vec_t;

   // kind: 0 action write, 1 mask write, 2 key write, 3 default write, 4 done
   typedef struct {
      int           kind;
      int           cyc;
      logic [3:0]   addr;
      logic [127:0] data;
   } ev_t;

   ev_t  sb_q[$];
   vec_t vecs[6];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic observe(input int kind, input int k, input logic [3:0] addr, input logic [127:0] data);
      ev_t e;
      if (sb_q.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL unexpected_strobe: kind %0d at cycle %0d, none expected", kind, k);
      end else begin
         e = sb_q.pop_front();
         chk("ev_kind", 128'(kind), 128'(e.kind));
         chk("ev_cycle", 128'(k), 128'(e.cyc));
         chk("ev_addr", 128'(addr), 128'(e.addr));
         chk("ev_data", data, e.data);
      end
   endtask

   task automatic check_reset_state();
      chk("rst_ctrl", 128'({hold_lookup, cfg_tcam_wr_en, cfg_tcam_wr_is_mask, cfg_action_wr_en,
                            cfg_action_wr_default, done, done_err, cnt_err}), 128'd0);
      chk("rst_ready", 128'(req_ready), 128'd1);
      chk("rst_tcam_data", cfg_tcam_wr_data, 128'd0);
      chk("rst_act_data", {cfg_action_wr_data, cfg_action_default_data}, 128'd0);
      chk("rst_addr", 128'({cfg_tcam_wr_addr, cfg_action_wr_addr}), 128'd0);
   endtask

   task automatic cycle_check(input vec_t v, input int k);
      chk("hold_lookup", 128'(hold_lookup), 128'(k < v.done_cyc));
      chk("req_ready", 128'(req_ready), 128'(k > v.done_cyc));
      if (cfg_action_wr_en) observe(0, k, cfg_action_wr_addr, {64'd0, cfg_action_wr_data});
      if (cfg_tcam_wr_en) observe(cfg_tcam_wr_is_mask ? 1 : 2, k, cfg_tcam_wr_addr, cfg_tcam_wr_data);
      if (cfg_action_wr_default) observe(3, k, 4'd0, {64'd0, cfg_action_default_data});
      if (done) observe(4, k, 4'd0, 128'(done_err));
      else chk("done_err_alone", 128'(done_err), 128'd0);
   endtask

   task automatic push_ev(input int kind, input int cyc, input logic [3:0] addr,
                          input logic [127:0] data, input int rst_at);
      if (rst_at == 0 || cyc <= rst_at) sb_q.push_back('{kind, cyc, addr, data});
   endtask

   // Starts and ends on a falling edge; cycle k = k-th output sample after the accept edge
   task automatic run_req(input vec_t v, input int rst_at);
      for (int i = 0; i < v.n_issue; i++) begin
         lookup_issue = 1'b1;
         @(negedge clk);
         lookup_issue = 1'b0;
      end
      chk("ready_before_req", 128'(req_ready), 128'd1);
      if (!v.exp_err) begin
         if (v.is_def) begin
            push_ev(3, v.done_cyc, 4'd0, {64'd0, v.act}, rst_at);
         end else begin
            push_ev(0, v.done_cyc - 3, v.addr, {64'd0, v.act}, rst_at);
            push_ev(1, v.done_cyc - 2, v.addr, v.mask, rst_at);
            push_ev(2, v.done_cyc - 1, v.addr, v.key, rst_at);
         end
      end
      push_ev(4, v.done_cyc, 4'd0, 128'(v.exp_err), rst_at);
      req_valid      = 1'b1;
      req_is_default = v.is_def;
      req_addr       = v.addr;
      req_key        = v.key;
      req_mask       = v.mask;
      req_action     = v.act;
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         cycle_check(v, k);
         lookup_retire = (k == v.ret1) || (k == v.ret2);
         if (k == rst_at) begin
            lookup_retire = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            check_reset_state();
            rst = 1'b0;
            break;
         end
         @(negedge clk);
      end
      lookup_retire = 1'b0;
      chk("sb_empty", 128'(sb_q.size()), 128'd0);
      sb_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 4'd3,  128'hC0A80001_00000000_00000000_00000000,
                  128'hFFFF0000_00000000_00000000_00000000, 64'h11, 0, 0, 0, 1'b0, 5};
      vecs[1] = '{1'b0, 4'd7,  128'h0A000001_12345678_9ABCDEF0_0F0F0F0F,
                  128'hFFFFFF00_FFFFFFFF_00000000_FFFF0000, 64'h2222_0000_3333, 2, 4, 6, 1'b0, 10};
      vecs[2] = '{1'b1, 4'd5,  128'h1, 128'h2, 64'hDEAD, 0, 0, 0, 1'b0, 2};
      vecs[3] = '{1'b0, 4'd9,  128'hAAAA, 128'hBBBB, 64'h77, 1, 12, 0, 1'b1, 9};
      vecs[4] = '{1'b0, 4'd15, 128'hFEDCBA98_76543210_01234567_89ABCDEF,
                  128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 64'hCAFE_F00D_0000_0001, 1, 1, 0, 1'b0, 5};
      vecs[5] = '{1'b1, 4'd2,  128'h5, 128'h6, 64'hBEEF_0001, 1, 3, 0, 1'b0, 4};

      rst = 1'b1;
      req_valid = 1'b0; req_is_default = 1'b0; req_addr = 4'd0;
      req_key = 128'd0; req_mask = 128'd0; req_action = 64'd0;
      lookup_issue = 1'b0; lookup_retire = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_reset_state();
      rst = 1'b0;
      @(negedge clk);

      // Retire with an empty pipeline sets the sticky error and leaves the counter at 0
      lookup_retire = 1'b1;
      @(negedge clk);
      lookup_retire = 1'b0;
      chk("cnt_err_underflow", 128'(cnt_err), 128'd1);
      // issue, issue+retire together, retire: counter must return to 0
      lookup_issue = 1'b1;
      @(negedge clk);
      lookup_retire = 1'b1;
      @(negedge clk);
      lookup_issue = 1'b0;
      @(negedge clk);
      lookup_retire = 1'b0;

      for (int i = 0; i < 6; i++) run_req(vecs[i], 0);
      chk("cnt_err_sticky", 128'(cnt_err), 128'd1);

      // Reset while WR_MASK is on the outputs, then a clean install
      run_req(vecs[0], 3);
      run_req(vecs[4], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tcam_rule_install_ctrl.md
Name: tcam_rule_install_ctrl

Overview:
- Sequences control-plane rule installs into the TCAM key/mask arrays and the action table.
- Before writing, it quiesces the lookup pipeline so no lookup ever sees a partially written rule.
- It sits between the PicoRV config bus and the dataplane cfg_tcam_* / cfg_action_* inputs.
- It stalls new lookups via hold_lookup and tracks in-flight lookups until the pipeline drains.

Parameters:
- KEY_W, 128, TCAM key and mask width
- ACTION_W, 64, action word width
- TCAM_ENTRIES, 16, entry count; IDX_W = $clog2(TCAM_ENTRIES)
- CNT_W, 4, width of the in-flight lookup counter
- DRAIN_TIMEOUT, 255, maximum number of STALL cycles before the install aborts

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  install request valid
- req_ready  out  1  high only in IDLE
- req_is_default  in  1  1 = write the default action only
- req_addr  in  IDX_W  entry index
- req_key  in  KEY_W  key value
- req_mask  in  KEY_W  mask value
- req_action  in  ACTION_W  action word
- lookup_issue  in  1  a lookup entered the TCAM stage (key_valid && key_ready)
- lookup_retire  in  1  a lookup left the action stage (action_valid)
- hold_lookup  out  1  stall request to the header/parser front end
- cfg_tcam_wr_en  out  1  TCAM write strobe
- cfg_tcam_wr_is_mask  out  1  1 = mask array, 0 = key array
- cfg_tcam_wr_addr  out  IDX_W  TCAM write index
- cfg_tcam_wr_data  out  KEY_W  TCAM write data
- cfg_action_wr_en  out  1  action entry write strobe
- cfg_action_wr_addr  out  IDX_W  action write index
- cfg_action_wr_data  out  ACTION_W  action entry data
- cfg_action_wr_default  out  1  default action write strobe
- cfg_action_default_data  out  ACTION_W  default action data
- done  out  1  one-cycle completion pulse
- done_err  out  1  valid with done; 1 = drain timeout, nothing written
- cnt_err  out  1  sticky flag; set on counter underflow or overflow

Behaviour:
- All outputs are registered. Reset values: every output 0, except req_ready = 1. State = IDLE, counter = 0, timeout counter = 0.
- Request capture: on req_valid && req_ready, all req_* fields are latched into internal registers. req_ready drops the next cycle.
- States: IDLE, STALL, WR_ACT, WR_MASK, WR_KEY, RELEASE.
  - IDLE: on accept → STALL.
  - STALL: hold_lookup = 1; the timeout counter increments each cycle.
    - If inflight == 0 and lookup_issue == 0 this cycle → WR_ACT for a normal request.
    - Same condition → RELEASE for a default request; that RELEASE cycle also asserts cfg_action_wr_default with the latched action.
    - If the timeout counter reaches DRAIN_TIMEOUT first → RELEASE with done_err = 1 and no writes.
    - A drain-complete and timeout event in the same cycle resolves as drain-complete.
  - WR_ACT: cfg_action_wr_en = 1, addr = latched addr, data = latched action. Next state WR_MASK.
  - WR_MASK: cfg_tcam_wr_en = 1, is_mask = 1, data = latched mask. Next state WR_KEY.
  - WR_KEY: cfg_tcam_wr_en = 1, is_mask = 0, data = latched key. Next state RELEASE.
  - RELEASE: done = 1; hold_lookup deasserts in this cycle. Next state IDLE.
- hold_lookup is high in STALL, WR_ACT, WR_MASK and WR_KEY.
- Write strobes are one cycle each, mutually exclusive, and only asserted while hold_lookup = 1. Data and address outputs hold their last value when not strobed.
- Latency with an empty pipeline: accept at T; STALL T+1; writes at T+2, T+3, T+4; done at T+5.
- In-flight counter:
  - Increment on lookup_issue; decrement on lookup_retire; no change when both are asserted.
  - Retire at 0 holds the counter at 0 and sets cnt_err.
  - Issue at all-ones holds the counter and sets cnt_err.
  - The counter tracks lookups in every state, including while hold_lookup is set; a lookup issued in the first hold cycle is counted and drained.
- cnt_err clears only on rst.
- Reset mid-sequence: return to IDLE immediately, drop all strobes and hold_lookup, discard the pending request, no done pulse.
- No request queueing: a new request is accepted only from IDLE.

Test Plan:
- Idle pipeline: request addr=3, key=0xC0A80001.., mask=0xFFFF0000.., action=0x11 → action write at T+2, mask at T+3, key at T+4, done at T+5 with done_err = 0.
- Two issues before the request, retires at T+4 and T+6 → STALL holds until the counter reaches 0; first write at T+7.
- Default request with action=0xDEAD → single cfg_action_wr_default pulse in the RELEASE cycle; no TCAM or action-entry writes; done = 1.
- DRAIN_TIMEOUT=8 with one issue and no retire → after 8 STALL cycles done = 1, done_err = 1, zero write strobes, hold_lookup returns to 0.
- Retire with counter at 0 → cnt_err = 1 and counter stays 0; issue and retire in the same cycle → counter unchanged.
- rst asserted during WR_MASK → next cycle all outputs at reset values and req_ready = 1; the following request completes normally.
